// File: rtl/player_projectile_scheduler.sv
// Player projectile slot manager: allocates up to three shots at the player's X,
// advances them upward on each game tick and retires them on hit or off-screen.
module player_projectile_scheduler #(
  parameter int PROJ_START_Y   = 440,
  parameter int PROJ_STEP      = 4,
  parameter int TOP_BOUNDARY   = 0,
  parameter int X_OFFSET       = 15,
  parameter int SCREEN_MAX_X   = 639,
  parameter int COOLDOWN_STEPS = 8
) (
  input  logic       clk_master,
  input  logic       rst,
  input  logic       pulse_stepCycle,
  input  logic       fireReq,
  input  logic [9:0] playerX,
  input  logic [2:0] playerHP,
  input  logic [2:0] projHit,
  output logic [2:0] projActive,
  output logic [9:0] proj1X,
  output logic [9:0] proj2X,
  output logic [9:0] proj3X,
  output logic [8:0] proj1Y,
  output logic [8:0] proj2Y,
  output logic [8:0] proj3Y,
  output logic       fireAck,
  output logic       cooldownBusy
);

  localparam logic [0:0] SLOT_IDLE   = 1'b0;
  localparam logic [0:0] SLOT_FLYING = 1'b1;

  localparam logic [8:0]  START_Y  = 9'(PROJ_START_Y);
  localparam logic [8:0]  STEP_Y   = 9'(PROJ_STEP);
  localparam logic [8:0]  RETIRE_Y = 9'(TOP_BOUNDARY + PROJ_STEP);
  localparam logic [10:0] OFFSET_X = 11'(X_OFFSET);
  localparam logic [10:0] MAX_X    = 11'(SCREEN_MAX_X);
  localparam logic [3:0]  CD_LOAD  = 4'(COOLDOWN_STEPS);

  // Each slot's state register is its bit of slot_state; projActive mirrors it.
  logic [2:0]  slot_state;
  logic [9:0]  slot_x [3];
  logic [8:0]  slot_y [3];
  logic [3:0]  cd_cnt;
  logic [3:0]  cd_next;
  logic        fire_ok;
  logic [2:0]  alloc;
  logic [10:0] spawn_sum;
  logic [9:0]  spawn_x;

  // Handshake: fireReq is a level request; fireAck pulses for one cycle in the
  // cycle after a request is accepted. There is no backpressure on fireAck.
  always_comb begin
    alloc[0] = (slot_state[0] == SLOT_IDLE);
    alloc[1] = (slot_state[0] == SLOT_FLYING) && (slot_state[1] == SLOT_IDLE);
    alloc[2] = (slot_state[0] == SLOT_FLYING) && (slot_state[1] == SLOT_FLYING) &&
               (slot_state[2] == SLOT_IDLE);
    fire_ok  = fireReq && (cd_cnt == 4'd0) && (playerHP != 3'd0) && (alloc != 3'b000);

    spawn_sum = {1'b0, playerX} + OFFSET_X;
    spawn_x   = (spawn_sum > MAX_X) ? MAX_X[9:0] : spawn_sum[9:0];

    cd_next = cd_cnt;
    if (fire_ok) begin
      cd_next = CD_LOAD;
    end else if (pulse_stepCycle && (cd_cnt != 4'd0)) begin
      cd_next = cd_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        slot_state[i] <= SLOT_IDLE;
        slot_x[i]     <= 10'd0;
        slot_y[i]     <= 9'd0;
      end
      cd_cnt       <= 4'd0;
      cooldownBusy <= 1'b0;
      fireAck      <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (fire_ok && alloc[i]) begin
          slot_state[i] <= SLOT_FLYING;
          slot_x[i]     <= spawn_x;
          slot_y[i]     <= START_Y;
        end else if (slot_state[i] == SLOT_FLYING) begin
          if (projHit[i] || (pulse_stepCycle && (slot_y[i] <= RETIRE_Y))) begin
            slot_state[i] <= SLOT_IDLE;
            slot_x[i]     <= 10'd0;
            slot_y[i]     <= 9'd0;
          end else if (pulse_stepCycle) begin
            slot_y[i] <= slot_y[i] - STEP_Y;
          end
        end
      end
      cd_cnt       <= cd_next;
      cooldownBusy <= (cd_next != 4'd0);
      fireAck      <= fire_ok;
    end
  end

  assign projActive = slot_state;
  assign proj1X     = slot_x[0];
  assign proj2X     = slot_x[1];
  assign proj3X     = slot_x[2];
  assign proj1Y     = slot_y[0];
  assign proj2Y     = slot_y[1];
  assign proj3Y     = slot_y[2];

endmodule

// File: tb/tb_player_projectile_scheduler.sv
// Bench for player_projectile_scheduler: directed fire/step/hit/reset scenarios,
// with accepted fires checked by a monitor against an expected queue.
module tb_player_projectile_scheduler;

  logic       clk;
  logic       rst;
  logic       pulse;
  logic       fire_req;
  logic [9:0] player_x;
  logic [2:0] player_hp;
  logic [2:0] proj_hit;
  logic [2:0] proj_active;
  logic [9:0] p1x, p2x, p3x;
  logic [8:0] p1y, p2y, p3y;
  logic       fire_ack;
  logic       cd_busy;

  int total;
  int bad;
  int ack_cnt;

  // Expected fire: {slot[1:0], x[9:0], y[8:0]}
  logic [20:0] exp_q[$];

  player_projectile_scheduler dut (
    .clk_master     (clk),
    .rst            (rst),
    .pulse_stepCycle(pulse),
    .fireReq        (fire_req),
    .playerX        (player_x),
    .playerHP       (player_hp),
    .projHit        (proj_hit),
    .projActive     (proj_active),
    .proj1X         (p1x),
    .proj2X         (p2x),
    .proj3X         (p3x),
    .proj1Y         (p1y),
    .proj2Y         (p2y),
    .proj3Y         (p3y),
    .fireAck        (fire_ack),
    .cooldownBusy   (cd_busy)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      pulse = 1'b1;
      tick(1);
      pulse = 1'b0;
      tick(9);
    end
  endtask

  task automatic push_fire(input int slot, input int x, input int y);
    logic [1:0] s;
    logic [9:0] xv;
    logic [8:0] yv;
    s  = 2'(slot);
    xv = 10'(x);
    yv = 9'(y);
    exp_q.push_back({s, xv, yv});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor: every fireAck must match the next queued fire
  always @(negedge clk) begin
    if (!rst && fire_ack) begin
      logic [20:0] e;
      int          ax;
      int          ay;
      int          aa;
      ack_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fireAck: got ack with empty queue, expected none");
      end else begin
        e = exp_q.pop_front();
        case (e[20:19])
          2'd0:    begin ax = int'(p1x); ay = int'(p1y); aa = int'(proj_active[0]); end
          2'd1:    begin ax = int'(p2x); ay = int'(p2y); aa = int'(proj_active[1]); end
          default: begin ax = int'(p3x); ay = int'(p3y); aa = int'(proj_active[2]); end
        endcase
        if (ax != int'(e[18:9]) || ay != int'(e[8:0]) || aa != 1) begin
          bad++;
          $display("FAIL fire_slot%0d: got x=%0d y=%0d act=%0d expected x=%0d y=%0d act=1",
                   e[20:19] + 1, ax, ay, aa, e[18:9], e[8:0]);
        end
      end
    end
  end

  // driver / directed sequence
  initial begin
    total = 0; bad = 0; ack_cnt = 0;
    rst = 1'b1; pulse = 1'b0; fire_req = 1'b0;
    player_x = 10'd100; player_hp = 3'd7; proj_hit = 3'b000;
    tick(2);
    chk("rst_active", proj_active, 0);
    chk("rst_p1x", p1x, 0);
    chk("rst_p3y", p3y, 0);
    chk("rst_ack", fire_ack, 0);
    chk("rst_busy", cd_busy, 0);

    // first fire
    rst = 1'b0;
    fire_req = 1'b1;
    push_fire(0, 115, 440);
    tick(1);
    fire_req = 1'b0;
    chk("fire1_active", proj_active, 3'b001);
    chk("fire1_x", p1x, 115);
    chk("fire1_y", p1y, 440);
    chk("fire1_ack", fire_ack, 1);
    chk("fire1_busy", cd_busy, 1);
    tick(1);
    chk("fire1_ack_drop", fire_ack, 0);

    // movement and off-screen retirement
    pulses(3);
    chk("move3_y", p1y, 428);
    pulses(106);
    chk("at4_y", p1y, 4);
    chk("at4_active", proj_active, 3'b001);
    chk("cd_expired", cd_busy, 0);
    pulses(1);
    chk("retire_active", proj_active, 3'b000);
    chk("retire_x", p1x, 0);
    chk("retire_y", p1y, 0);

    // held fireReq: one fire per cooldown, slots in order, 4th rejected
    fire_req = 1'b1;
    push_fire(0, 115, 440);
    push_fire(1, 115, 440);
    push_fire(2, 115, 440);
    tick(1);
    pulses(30);
    chk("hold_ack_cnt", ack_cnt, 4);
    chk("hold_active", proj_active, 3'b111);
    chk("hold_busy", cd_busy, 0);
    chk("hold_p1y", p1y, 320);
    chk("hold_p2y", p2y, 352);
    chk("hold_p3y", p3y, 384);
    fire_req = 1'b0;

    // hit with simultaneous step and rejected fire
    pulses(38);
    chk("pre_hit_p2y", p2y, 200);
    proj_hit = 3'b010; pulse = 1'b1; fire_req = 1'b1;
    tick(1);
    proj_hit = 3'b000; pulse = 1'b0;
    chk("hit_active", proj_active, 3'b101);
    chk("hit_p2x", p2x, 0);
    chk("hit_p2y", p2y, 0);
    chk("hit_ack", fire_ack, 0);
    chk("hit_p1y", p1y, 164);
    chk("hit_p3y", p3y, 228);
    push_fire(1, 115, 440);
    tick(1);
    fire_req = 1'b0;
    chk("refill_active", proj_active, 3'b111);

    // spawn X saturation
    proj_hit = 3'b001;
    tick(1);
    proj_hit = 3'b000;
    chk("hit1_active", proj_active, 3'b110);
    pulses(8);
    player_x = 10'd630;
    fire_req = 1'b1;
    push_fire(0, 639, 440);
    tick(1);
    fire_req = 1'b0;
    chk("sat_x", p1x, 639);

    // game over: no fire, flight continues
    proj_hit = 3'b001;
    tick(1);
    proj_hit = 3'b000;
    pulses(8);
    player_hp = 3'd0;
    fire_req = 1'b1;
    tick(2);
    chk("gameover_active", proj_active, 3'b110);
    chk("gameover_busy", cd_busy, 0);
    pulses(1);
    chk("gameover_p2y", p2y, 372);
    chk("gameover_p3y", p3y, 160);
    chk("gameover_acks", ack_cnt, 6);

    // reset mid-flight, then immediate fire
    player_hp = 3'd7;
    player_x = 10'd100;
    push_fire(0, 115, 440);
    tick(1);
    fire_req = 1'b0;
    chk("prerst_active", proj_active, 3'b111);
    pulses(3);
    chk("prerst_busy", cd_busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_active", proj_active, 0);
    chk("midrst_p2y", p2y, 0);
    chk("midrst_p3x", p3x, 0);
    chk("midrst_busy", cd_busy, 0);
    fire_req = 1'b1;
    push_fire(0, 115, 440);
    tick(1);
    fire_req = 1'b0;
    chk("postrst_active", proj_active, 3'b001);
    chk("postrst_ack", fire_ack, 1);
    tick(2);

    chk("final_ack_cnt", ack_cnt, 8);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
